// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the FIFO pointer/status controller.
// Transfer encoding and modulo-DEPTH pointer increment.
package fifo_ctrl_pkg;

    // Encoded as {wr_en, rd_en}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

    // Anything at or beyond the last slot wraps, so an out-of-range pointer self-heals
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
        logic [31:0] w_res;
        if (ptr >= depth - 32'd1) begin
            w_res = '0;
        end else begin
            w_res = ptr + 32'd1;
        end
        return w_res;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Single FIFO pointer: advances on an accepted transfer, wraps at DEPTH-1,
// returns to zero on flush or asynchronous reset.
module fifo_ptr
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_inc,
    input  logic                  i_flush,
    output logic [ADDR_WIDTH-1:0] o_ptr
);

    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] w_ptr_next;

    always_comb begin
        w_ptr_next = r_ptr;
        if (i_flush) begin
            w_ptr_next = '0;
        end else if (i_inc) begin
            w_ptr_next = ADDR_WIDTH'(ptr_inc(32'(r_ptr), 32'(DEPTH)));
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl_lvl.sv
// FIFO pointer/status controller: accepted-transfer strobes, wrapping pointers,
// occupancy level, registered full/empty/almost flags and sticky error flags.
module fifo_ctrl_lvl
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic [ADDR_WIDTH:0]   af_th,
    input  logic [ADDR_WIDTH:0]   ae_th,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int              LW      = ADDR_WIDTH + 1;
    localparam logic [LW-1:0]   DEPTH_L = LW'(DEPTH);

    logic [LW-1:0] r_level;
    logic [LW-1:0] w_level_next;
    logic          r_full;
    logic          r_empty;
    logic          r_almost_full;
    logic          r_almost_empty;
    logic          r_overflow;
    logic          r_underflow;
    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_ovf_set;
    logic          w_unf_set;
    fifo_op_e      w_op;

    // A write into a full FIFO is legal only when a read frees the slot in the same cycle
    always_comb begin
        w_rd_en   = rd & ~r_empty & ~flush;
        w_wr_en   = wr & (~r_full | rd) & ~flush;
        w_op      = fifo_op_e'({w_wr_en, w_rd_en});
        w_ovf_set = wr & r_full & ~rd & ~flush;
        w_unf_set = rd & r_empty & ~flush;
    end

    always_comb begin
        w_level_next = r_level;
        if (flush) begin
            w_level_next = '0;
        end else begin
            case (w_op)
                OP_WR:   w_level_next = r_level + LW'(1);
                OP_RD:   w_level_next = r_level - LW'(1);
                default: w_level_next = r_level;
            endcase
        end
    end

    fifo_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_wr_ptr (
        .i_clk   (clk),
        .i_reset (reset),
        .i_inc   (w_wr_en),
        .i_flush (flush),
        .o_ptr   (w_addr)
    );

    fifo_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_rd_ptr (
        .i_clk   (clk),
        .i_reset (reset),
        .i_inc   (w_rd_en),
        .i_flush (flush),
        .o_ptr   (r_addr)
    );

    // Flags are registered from the next level so they never depend combinationally on wr/rd
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_level        <= w_level_next;
            r_full         <= (w_level_next == DEPTH_L);
            r_empty        <= (w_level_next == '0);
            r_almost_full  <= (w_level_next >= af_th);
            r_almost_empty <= (w_level_next <= ae_th);
        end
    end

    // Sticky errors survive flush; a new error outranks a coincident clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_unf_set) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign wr_en        = w_wr_en;
    assign rd_en        = w_rd_en;
    assign level        = r_level;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
